// File: rtl/pbuf_reader.sv
// Streams len_i consecutive words out of the P result buffer as a valid/ready stream.
// A 2-entry FIFO plus credit-gated read issue keeps the stream lossless under backpressure.
module pbuf_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  enp_o,
  output logic                  wep_o,
  output logic [ADDR_WIDTH-1:0] addrp_o,
  input  logic [WORD_WIDTH-1:0] wordp_i,
  output logic [WORD_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   remaining_q;
  logic [ADDR_WIDTH-1:0]   len_q;
  logic [ADDR_WIDTH-1:0]   beat_q;
  logic                    inflight_q;
  logic [WORD_WIDTH-1:0]   fifo_q [2];
  logic                    rd_ptr_q;
  logic                    wr_ptr_q;
  logic [1:0]              count_q;

  logic [2:0]              occupancy;
  logic                    bypass;
  logic                    pop;
  logic                    fifo_pop;
  logic                    push;
  logic                    issue;
  logic                    accept;

  // The word returning from P this cycle is presented directly when the FIFO is empty,
  // so the first beat appears the cycle after its read; it is only stored if not taken.
  assign bypass    = (count_q == 2'd0) && inflight_q;
  assign m_valid_o = (count_q != 2'd0) || inflight_q;
  assign m_data_o  = bypass ? wordp_i : fifo_q[rd_ptr_q];
  assign m_last_o  = m_valid_o && (beat_q == len_q - ADDR_WIDTH'(1));

  assign pop       = m_valid_o && m_ready_i;
  assign fifo_pop  = pop && (count_q != 2'd0);
  assign push      = inflight_q && !(bypass && pop);

  // Buffered plus in-flight words may never exceed the two FIFO slots.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q};
  assign issue     = (state_q == RUN) && (remaining_q != '0) &&
                     ((occupancy - {2'b00, pop}) < 3'd2);

  assign accept    = (state_q == IDLE) && start_i;

  assign enp_o     = issue;
  assign wep_o     = 1'b0;
  assign addrp_o   = addr_q;
  assign busy_o    = (state_q == RUN) || (state_q == DRAIN);
  assign done_o    = (state_q == DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Beats leave in address order, so handshaking the last beat means nothing is left behind it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (len_i == '0) ? DONE : RUN;
      RUN:     if (issue && (remaining_q == ADDR_WIDTH'(1))) state_d = DRAIN;
      DRAIN:   if (pop && m_last_o) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (accept) begin
        addr_q      <= base_addr_i;
        remaining_q <= len_i;
        len_q       <= len_i;
        beat_q      <= '0;
      end else begin
        if (issue) begin
          addr_q      <= addr_q + ADDR_WIDTH'(1);
          remaining_q <= remaining_q - ADDR_WIDTH'(1);
        end
        if (pop) begin
          beat_q <= beat_q + ADDR_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= wordp_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (fifo_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, fifo_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_pbuf_reader.sv
// Bench for pbuf_reader: synchronous P memory model, randomized ready, and a
// transaction-level model that predicts every output each cycle.
module tb_pbuf_reader;

  localparam int AW = 16;
  localparam int WW = 128;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [AW-1:0] len_i;
  logic          busy_o;
  logic          done_o;
  logic          enp_o;
  logic          wep_o;
  logic [AW-1:0] addrp_o;
  logic [WW-1:0] wordp_i;
  logic [WW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_last_o;
  logic          m_ready_i;

  pbuf_reader #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .enp_o      (enp_o),
    .wep_o      (wep_o),
    .addrp_o    (addrp_o),
    .wordp_i    (wordp_i),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_last_o   (m_last_o),
    .m_ready_i  (m_ready_i)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [31:0]   seed = 32'h1234_5678;
  logic [AW-1:0] exp_base = '0;
  int            exp_len = 0;
  int            issued = 0;
  int            popped = 0;
  bit            done_emitted = 1'b1;
  bit            tracking = 1'b0;
  int            cyc = 0;
  int            first_enp_cyc = -1;
  int            first_valid_cyc = -1;
  int            last_beat_cyc = -1;
  int            done_cyc = -1;
  int            last_count = 0;
  int            issued_at9 = -1;
  logic [AW-1:0] addr_log[$];
  logic          rd_en_q = 1'b0;
  logic [AW-1:0] rd_addr_q = '0;

  // Contents of P are a per-transfer pseudo-random function of the address.
  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    return {seed ^ {16'h0000, a}, ~seed, a, ~a, seed + {a, 16'h5A5A}};
  endfunction

  function automatic logic readyFor(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return !(c >= 2 && c <= 9);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_busy",   128'(busy_o),    128'(0));
    checkOutput("rst_done",   128'(done_o),    128'(0));
    checkOutput("rst_enp",    128'(enp_o),     128'(0));
    checkOutput("rst_wep",    128'(wep_o),     128'(0));
    checkOutput("rst_valid",  128'(m_valid_o), 128'(0));
    checkOutput("rst_last",   128'(m_last_o),  128'(0));
    checkOutput("rst_addrp",  128'(addrp_o),   128'(0));
    checkOutput("rst_mdata",  m_data_o,        128'(0));
  endtask

  // Synchronous-read P: the address seen during an enp_o cycle returns data the next cycle.
  always @(negedge clk) begin
    rd_en_q   = enp_o;
    rd_addr_q = addrp_o;
  end

  always @(posedge clk) begin
    #1;
    if (rd_en_q) wordp_i = mem_word(rd_addr_q);
  end

  // Model: a word is available from the cycle after its read until handshaken;
  // reads run in order while fewer than two words are issued but not yet taken.
  always @(negedge clk) begin : compare
    int avail;
    bit exp_valid;
    bit exp_pop;
    bit exp_enp;
    bit exp_done;
    bit exp_busy;
    if (tracking) begin
      avail     = issued - popped;
      exp_valid = avail > 0;
      exp_pop   = exp_valid && m_ready_i;
      exp_enp   = !done_emitted && (issued < exp_len) && ((avail - int'(exp_pop)) < 2);
      exp_done  = !done_emitted && (popped == exp_len);
      exp_busy  = !done_emitted && !exp_done;

      checkOutput("enp_o",     128'(enp_o),     128'(exp_enp));
      checkOutput("wep_o",     128'(wep_o),     128'(0));
      checkOutput("m_valid_o", 128'(m_valid_o), 128'(exp_valid));
      checkOutput("busy_o",    128'(busy_o),    128'(exp_busy));
      checkOutput("done_o",    128'(done_o),    128'(exp_done));

      if (enp_o && first_enp_cyc < 0) first_enp_cyc = cyc;
      if (m_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid_o && m_last_o && m_ready_i) begin
        last_count++;
        last_beat_cyc = cyc;
      end
      if (done_o) done_cyc = cyc;

      if (exp_enp && enp_o) begin
        checkOutput("addrp_o", 128'(addrp_o), 128'(16'(exp_base + issued)));
        addr_log.push_back(addrp_o);
      end
      if (exp_valid) begin
        checkOutput("m_data_o", m_data_o, mem_word(16'(exp_base + popped)));
        checkOutput("m_last_o", 128'(m_last_o), 128'(popped == exp_len - 1));
        if (exp_pop) popped++;
      end
      if (exp_enp) issued++;
      if (exp_done) done_emitted = 1'b1;
      if (cyc == 9) issued_at9 = issued;
    end
  end

  // Runs one transfer; returns one ns after the edge that follows done_o, or at abort_at.
  task automatic applyStimulus(input logic [AW-1:0] b, input int l, input int mode,
                               input int stray, input int abort_at);
    seed        = $urandom;
    start_i     = 1'b1;
    base_addr_i = b;
    len_i       = 16'(l);
    m_ready_i   = 1'b1;
    @(posedge clk);
    #1;
    start_i         = 1'b0;
    base_addr_i     = 16'($urandom);
    len_i           = 16'($urandom);
    exp_base        = b;
    exp_len         = l;
    issued          = 0;
    popped          = 0;
    last_count      = 0;
    first_enp_cyc   = -1;
    first_valid_cyc = -1;
    last_beat_cyc   = -1;
    done_cyc        = -1;
    issued_at9      = -1;
    addr_log.delete();
    cyc             = 1;
    m_ready_i       = readyFor(mode, 1);
    done_emitted    = 1'b0;
    while (!done_emitted) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      cyc++;
      if (cyc == abort_at) break;
      if (cyc > 2000) begin
        checkOutput("timeout", 128'(0), 128'(1));
        done_emitted = 1'b1;
        break;
      end
      m_ready_i = readyFor(mode, cyc);
      if (cyc == stray) begin
        start_i     = 1'b1;
        base_addr_i = 16'($urandom);
        len_i       = 16'd5;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    len_i       = '0;
    m_ready_i   = 1'b0;
    wordp_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs();
    rst_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tracking = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] basic transfer base=0x0010 len=4");
    applyStimulus(16'h0010, 4, 0, 0, 0);
    checkOutput("t1_first_enp_cyc",   128'(first_enp_cyc),   128'(1));
    checkOutput("t1_first_valid_cyc", 128'(first_valid_cyc), 128'(2));
    checkOutput("t1_last_beat_cyc",   128'(last_beat_cyc),   128'(5));
    checkOutput("t1_done_cyc",        128'(done_cyc),        128'(6));
    checkOutput("t1_last_count",      128'(last_count),      128'(1));
    checkOutput("t1_addr_count",      128'(addr_log.size()), 128'(4));
    if (addr_log.size() == 4) begin
      checkOutput("t1_addr0", 128'(addr_log[0]), 128'(16'h0010));
      checkOutput("t1_addr3", 128'(addr_log[3]), 128'(16'h0013));
    end

    $display("[TB] zero-length transfer");
    applyStimulus(16'h1234, 0, 0, 0, 0);
    checkOutput("z_done_cyc",    128'(done_cyc),        128'(1));
    checkOutput("z_no_enp",      128'(first_enp_cyc),   128'(-1));
    checkOutput("z_no_valid",    128'(first_valid_cyc), 128'(-1));
    checkOutput("z_busy_after",  128'(busy_o),          128'(0));

    $display("[TB] address wrap base=0xFFFE len=4");
    applyStimulus(16'hFFFE, 4, 0, 0, 0);
    checkOutput("w_addr_count", 128'(addr_log.size()), 128'(4));
    if (addr_log.size() == 4) begin
      checkOutput("w_addr0", 128'(addr_log[0]), 128'(16'hFFFE));
      checkOutput("w_addr1", 128'(addr_log[1]), 128'(16'hFFFF));
      checkOutput("w_addr2", 128'(addr_log[2]), 128'(16'h0000));
      checkOutput("w_addr3", 128'(addr_log[3]), 128'(16'h0001));
    end

    $display("[TB] backpressure len=8, ready low in cycles 2-9");
    applyStimulus(16'h0400, 8, 2, 0, 0);
    checkOutput("bp_issued_by_9",  128'(issued_at9),    128'(2));
    checkOutput("bp_last_beat_cyc", 128'(last_beat_cyc), 128'(17));
    checkOutput("bp_done_cyc",     128'(done_cyc),      128'(18));
    checkOutput("bp_last_count",   128'(last_count),    128'(1));

    $display("[TB] random ready len=100");
    applyStimulus(16'($urandom), 100, 1, 0, 0);
    checkOutput("r_beats",      128'(popped),     128'(100));
    checkOutput("r_last_count", 128'(last_count), 128'(1));
    checkOutput("r_done_after_last", 128'(done_cyc), 128'(last_beat_cyc + 1));

    for (int k = 0; k < 4; k++) begin
      applyStimulus(16'($urandom), $urandom_range(1, 12), 1, 0, 0);
      checkOutput("rs_last_count", 128'(last_count), 128'(1));
    end

    $display("[TB] reset during len=10 transfer, then len=2 with stray start");
    applyStimulus(16'h0200, 10, 0, 0, 3);
    rst_ni   = 1'b0;
    tracking = 1'b0;
    #1;
    checkResetOutputs();
    @(posedge clk);
    #1;
    checkResetOutputs();
    @(posedge clk);
    #1;
    rst_ni       = 1'b1;
    exp_len      = 0;
    issued       = 0;
    popped       = 0;
    done_emitted = 1'b1;
    tracking     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(16'h0300, 2, 0, 2, 0);
    checkOutput("rr_beats",      128'(popped),     128'(2));
    checkOutput("rr_last_count", 128'(last_count), 128'(1));
    checkOutput("rr_done_cyc",   128'(done_cyc),   128'(4));
    repeat (8) @(posedge clk);
    #1;
    checkOutput("rr_idle_busy", 128'(busy_o), 128'(0));

    tracking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
